bus_interconnect_4: RTL and testbench
=====================================

BUS_INTERCONNECT_4 -- requirements
Module: bus_interconnect_4

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, RAM word-address width.
REQ-002 SHALL have parameter ROM_AW, default 17, ROM word-address width.
REQ-003 SHALL have parameter MMI_AW, default 3, MMI word-address width.
REQ-004 SHALL have parameter RAM_LAT, default 1, RAM read latency in cycles (1..15).
REQ-005 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles (1..15).
REQ-006 SHALL have parameter MMI_TIMEOUT, default 255, cycles to wait for mmi_ready before error (1..65535).
REQ-007 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-008 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-009 SHALL have port mem_valid  in  1  CPU request valid.
REQ-010 SHALL have port mem_instr  in  1  CPU request is instruction fetch.
REQ-011 SHALL have port mem_addr  in  32  CPU byte address.
REQ-012 SHALL have port mem_wstrb  in  4  CPU byte write strobes (0 = read).
REQ-013 SHALL have port mem_wdata  in  32  CPU write data.
REQ-014 SHALL have port mem_ready  out  1  transfer complete, one-cycle pulse.
REQ-015 SHALL have port mem_rdata  out  32  read data to CPU.
REQ-016 SHALL have port slv_wstrb  out  4  = mem_wstrb, shared by RAM and MMI.
REQ-017 SHALL have port slv_wdata  out  32  = mem_wdata, shared by RAM and MMI.
REQ-018 SHALL have port mmi_valid  out  1  MMI request.
REQ-019 SHALL have port mmi_addr  out  MMI_AW  = mem_addr[MMI_AW+1:2].
REQ-020 SHALL have port mmi_ready  in  1  MMI completion.
REQ-021 SHALL have port mmi_rdata  in  32  MMI read data.
REQ-022 SHALL have port ram_en  out  1  RAM enable.
REQ-023 SHALL have port ram_addr  out  RAM_AW  = mem_addr[RAM_AW+1:2].
REQ-024 SHALL have port ram_rdata  in  32  RAM read data.
REQ-025 SHALL have port rom_en  out  1  ROM enable.
REQ-026 SHALL have port rom_addr  out  ROM_AW  = mem_addr[ROM_AW+1:2].
REQ-027 SHALL have port rom_rdata  in  32  ROM read data.
REQ-028 SHALL have port bus_err  out  1  sticky error flag.
REQ-029 SHALL have port err_addr  out  32  mem_addr of first error since last clear.
REQ-030 SHALL have port err_clr  in  1  clears bus_err.

Function
REQ-031 SHALL decode mem_addr[21:20]: 00 ROM, 01 MMI, 10 RAM, 11 unmapped.
REQ-032 SHALL classify as error: unmapped; ROM with mem_wstrb!=0; MMI with mem_instr=1 (RAM fetch and ROM data read are legal).
REQ-033 SHALL implement FSM IDLE, WAIT, ERR, DONE; request accepted in IDLE when mem_valid=1 (cycle t).
REQ-034 SHALL for ROM/RAM: assert rom_en/ram_en from t through t+LAT (LAT per region), pulse mem_ready in t+LAT, then DONE.
REQ-035 SHALL for MMI: assert mmi_valid from t while in IDLE/WAIT; mem_ready = mmi_ready in any such cycle (zero-wait allowed), then DONE.
REQ-036 SHALL, if mmi_ready stays low for MMI_TIMEOUT cycles from t, drop mmi_valid and enter ERR.
REQ-037 SHALL for decode error: no slave enable, enter ERR at t+1; ERR pulses mem_ready with mem_rdata=32'hBADB_ADBA, then DONE.
REQ-038 SHALL in DONE assert no enable and no mem_ready, ignore mem_valid, return to IDLE next cycle.
REQ-039 SHALL drive mem_rdata in ready cycle from the serving slave, capture it in a hold register, and output the hold value otherwise.
REQ-040 SHALL set bus_err and, only if bus_err was 0, load err_addr on entering ERR; err_clr clears bus_err; simultaneous set and clear: set wins.
REQ-041 SHALL keep at most one slave enable high in any cycle.

Reset
REQ-042 SHALL with reset=0 at a clock edge: FSM IDLE, counters 0, hold register 0, bus_err 0, err_addr 0; enables and mem_ready 0 in the following cycle.
REQ-043 SHALL abort an in-flight transfer on reset without mem_ready; new request accepted in the first cycle after reset=1.

Verification
REQ-044 ROM fetch 0x0000_0100, ROM_LAT=1 -> rom_en t..t+1, rom_addr=0x40, mem_ready at t+1, mem_rdata=rom_rdata.
REQ-045 RAM write 0x0020_0008, wstrb=0xF, RAM_LAT=3 -> ram_en t..t+3, ram_addr=2, mem_ready at t+3 only, DONE at t+4.
REQ-046 MMI read 0x0010_0004, mmi_ready at t+5 -> mmi_addr=1, mem_ready t+5, mem_rdata=mmi_rdata, held after.
REQ-047 MMI, mmi_ready never, MMI_TIMEOUT=4 -> mmi_valid low after t+3, mem_ready at t+5, rdata 0xBADBADBA, bus_err=1, err_addr=0x0010_0004.
REQ-048 Access 0x0030_0000, then ROM write 0x0000_0010 -> both error, err_addr=0x0030_0000; err_clr with third error same cycle -> bus_err stays 1.
REQ-049 reset=0 at t+1 of RAM_LAT=3 access -> no mem_ready, ram_en 0 from t+2, bus_err 0.

Source files
------------

// File: rtl/bus_interconnect_4_if.sv
// Bus bundle for bus_interconnect_4: CPU request/response, shared slave
// write path, per-slave handshakes and the sticky error report.
// "slave" is the interconnect's view; "master" is the surrounding system
// (CPU plus the ROM/RAM/MMI devices) that drives requests and responses.
interface bus_interconnect_4_if #(
   parameter int RAM_AW = 14,
   parameter int ROM_AW = 17,
   parameter int MMI_AW = 3
);
   // CPU side
   logic              mem_valid;
   logic              mem_instr;
   logic [31:0]       mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic [31:0]       mem_rdata;
   // Write path shared by RAM and MMI
   logic [3:0]        slv_wstrb;
   logic [31:0]       slv_wdata;
   // Memory-mapped I/O
   logic              mmi_valid;
   logic [MMI_AW-1:0] mmi_addr;
   logic              mmi_ready;
   logic [31:0]       mmi_rdata;
   // RAM
   logic              ram_en;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_rdata;
   // ROM
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_rdata;
   // Error reporting
   logic              bus_err;
   logic [31:0]       err_addr;
   logic              err_clr;

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      input  mmi_ready, mmi_rdata, ram_rdata, rom_rdata, err_clr,
      output mem_ready, mem_rdata, slv_wstrb, slv_wdata,
      output mmi_valid, mmi_addr, ram_en, ram_addr, rom_en, rom_addr,
      output bus_err, err_addr
   );

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wstrb, mem_wdata,
      output mmi_ready, mmi_rdata, ram_rdata, rom_rdata, err_clr,
      input  mem_ready, mem_rdata, slv_wstrb, slv_wdata,
      input  mmi_valid, mmi_addr, ram_en, ram_addr, rom_en, rom_addr,
      input  bus_err, err_addr
   );
endinterface

// File: rtl/bus_interconnect_4.sv
// bus_interconnect_4: routes one outstanding CPU request to ROM, MMI or RAM
// by mem_addr[21:20], times fixed-latency memories and the MMI handshake,
// turns illegal accesses and MMI timeouts into an error response, and
// keeps a sticky error flag with the address of the first failing access.
module bus_interconnect_4 #(
   parameter int RAM_AW      = 14,
   parameter int ROM_AW      = 17,
   parameter int MMI_AW      = 3,
   parameter int RAM_LAT     = 1,
   parameter int ROM_LAT     = 1,
   parameter int MMI_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   bus_interconnect_4_if.slave bus
);
   localparam logic [31:0] ERR_RDATA  = 32'hBADB_ADBA;
   localparam logic [15:0] RAM_LAT_C  = 16'(RAM_LAT);
   localparam logic [15:0] ROM_LAT_C  = 16'(ROM_LAT);
   localparam logic [15:0] MMI_TO_C   = 16'(MMI_TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR, S_DONE} state_t;
   typedef enum logic [1:0] {
      R_ROM  = 2'b00,
      R_MMI  = 2'b01,
      R_RAM  = 2'b10,
      R_NONE = 2'b11
   } region_t;

   state_t      state_reg, state_next;
   region_t     region_reg, region_next;
   logic [15:0] cnt_reg, cnt_next;        // cycles elapsed since acceptance
   logic [31:0] addr_reg, addr_next;      // address of the request in flight
   logic [31:0] hold_reg;                 // last data returned to the CPU
   logic        bus_err_reg;
   logic [31:0] err_addr_reg;

   region_t     dec_region;
   logic        dec_err;
   logic        rom_en_sel;
   logic        ram_en_sel;
   logic        mmi_valid_sel;
   logic        mem_ready_sel;
   logic [31:0] rdata_sel;
   logic        err_enter;

   // Decode the live request into a region and flag illegal accesses
   always_comb begin
      dec_region = region_t'(bus.mem_addr[21:20]);
      dec_err    = 1'b0;
      case (dec_region)
         R_ROM:   dec_err = (bus.mem_wstrb != 4'h0);
         R_MMI:   dec_err = bus.mem_instr;
         R_RAM:   dec_err = 1'b0;
         default: dec_err = 1'b1;
      endcase
   end

   // Next-state and output logic; at most one slave enable is ever raised
   always_comb begin
      state_next    = state_reg;
      region_next   = region_reg;
      cnt_next      = cnt_reg;
      addr_next     = addr_reg;
      rom_en_sel    = 1'b0;
      ram_en_sel    = 1'b0;
      mmi_valid_sel = 1'b0;
      mem_ready_sel = 1'b0;
      rdata_sel     = hold_reg;

      case (state_reg)
         S_IDLE: begin
            // While reset is asserted nothing new is accepted
            if (reset && bus.mem_valid) begin
               region_next = dec_region;
               addr_next   = bus.mem_addr;
               cnt_next    = 16'd1;
               if (dec_err) begin
                  state_next = S_ERR;
               end else begin
                  case (dec_region)
                     R_ROM: begin
                        rom_en_sel = 1'b1;
                        state_next = S_WAIT;
                     end
                     R_RAM: begin
                        ram_en_sel = 1'b1;
                        state_next = S_WAIT;
                     end
                     R_MMI: begin
                        mmi_valid_sel = 1'b1;
                        if (bus.mmi_ready) begin
                           mem_ready_sel = 1'b1;
                           rdata_sel     = bus.mmi_rdata;
                           state_next    = S_DONE;
                        end else begin
                           state_next = S_WAIT;
                        end
                     end
                     default: state_next = S_ERR;
                  endcase
               end
            end
         end

         S_WAIT: begin
            cnt_next = cnt_reg + 16'd1;
            case (region_reg)
               R_ROM: begin
                  rom_en_sel = 1'b1;
                  if (cnt_reg == ROM_LAT_C) begin
                     mem_ready_sel = 1'b1;
                     rdata_sel     = bus.rom_rdata;
                     state_next    = S_DONE;
                  end
               end
               R_RAM: begin
                  ram_en_sel = 1'b1;
                  if (cnt_reg == RAM_LAT_C) begin
                     mem_ready_sel = 1'b1;
                     rdata_sel     = bus.ram_rdata;
                     state_next    = S_DONE;
                  end
               end
               R_MMI: begin
                  // After MMI_TIMEOUT cycles of silence the request is withdrawn
                  if (cnt_reg >= MMI_TO_C) begin
                     state_next = S_ERR;
                  end else begin
                     mmi_valid_sel = 1'b1;
                     if (bus.mmi_ready) begin
                        mem_ready_sel = 1'b1;
                        rdata_sel     = bus.mmi_rdata;
                        state_next    = S_DONE;
                     end
                  end
               end
               default: state_next = S_DONE;
            endcase
         end

         S_ERR: begin
            mem_ready_sel = 1'b1;
            rdata_sel     = ERR_RDATA;
            state_next    = S_DONE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign err_enter = (state_next == S_ERR) && (state_reg != S_ERR);

   // FSM, counter and request registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         region_reg <= R_ROM;
         cnt_reg    <= 16'd0;
         addr_reg   <= 32'd0;
      end else begin
         state_reg  <= state_next;
         region_reg <= region_next;
         cnt_reg    <= cnt_next;
         addr_reg   <= addr_next;
      end
   end

   // Read-data hold register, refreshed on every completed transfer
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_reg <= 32'd0;
      end else if (mem_ready_sel) begin
         hold_reg <= rdata_sel;
      end
   end

   // Sticky error flag; a new error beats a simultaneous clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus_err_reg  <= 1'b0;
         err_addr_reg <= 32'd0;
      end else if (err_enter) begin
         bus_err_reg <= 1'b1;
         if (!bus_err_reg) begin
            err_addr_reg <= addr_next;
         end
      end else if (bus.err_clr) begin
         bus_err_reg <= 1'b0;
      end
   end

   assign bus.rom_en    = rom_en_sel;
   assign bus.ram_en    = ram_en_sel;
   assign bus.mmi_valid = mmi_valid_sel;
   assign bus.mem_ready = mem_ready_sel;
   assign bus.mem_rdata = rdata_sel;
   assign bus.slv_wstrb = bus.mem_wstrb;
   assign bus.slv_wdata = bus.mem_wdata;
   assign bus.mmi_addr  = bus.mem_addr[MMI_AW+1:2];
   assign bus.ram_addr  = bus.mem_addr[RAM_AW+1:2];
   assign bus.rom_addr  = bus.mem_addr[ROM_AW+1:2];
   assign bus.bus_err   = bus_err_reg;
   assign bus.err_addr  = err_addr_reg;
endmodule

// File: tb/tb_bus_interconnect_4.sv
// Directed bench for bus_interconnect_4. u_dut uses MMI_TIMEOUT=4 for the
// timeout case; u_dut_slow keeps the default timeout for the slow-MMI case.
// Expected read data is queued when a request is issued and compared when
// the selected DUT pulses mem_ready.
module tb_bus_interconnect_4;
   localparam int RAM_AW = 14;
   localparam int ROM_AW = 17;
   localparam int MMI_AW = 3;
   localparam logic [31:0] BAD = 32'hBADB_ADBA;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mmi_ready = 1'b0;
   logic [31:0] mmi_rdata = 32'd0;
   logic [31:0] ram_rdata = 32'd0;
   logic [31:0] rom_rdata = 32'd0;
   logic        err_clr = 1'b0;
   logic        use_slow = 1'b0;

   int          check_cnt = 0;
   int          pass_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_rd;

   logic [3:0]  act_ctl;
   logic [31:0] act_rdata;

   always #5 clk = ~clk;

   bus_interconnect_4_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .MMI_AW(MMI_AW)) bus_a ();
   bus_interconnect_4_if #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .MMI_AW(MMI_AW)) bus_b ();

   assign bus_a.mem_valid = mem_valid & ~use_slow;
   assign bus_a.mem_instr = mem_instr;
   assign bus_a.mem_addr  = mem_addr;
   assign bus_a.mem_wstrb = mem_wstrb;
   assign bus_a.mem_wdata = mem_wdata;
   assign bus_a.mmi_ready = mmi_ready;
   assign bus_a.mmi_rdata = mmi_rdata;
   assign bus_a.ram_rdata = ram_rdata;
   assign bus_a.rom_rdata = rom_rdata;
   assign bus_a.err_clr   = err_clr;

   assign bus_b.mem_valid = mem_valid & use_slow;
   assign bus_b.mem_instr = mem_instr;
   assign bus_b.mem_addr  = mem_addr;
   assign bus_b.mem_wstrb = mem_wstrb;
   assign bus_b.mem_wdata = mem_wdata;
   assign bus_b.mmi_ready = mmi_ready;
   assign bus_b.mmi_rdata = mmi_rdata;
   assign bus_b.ram_rdata = ram_rdata;
   assign bus_b.rom_rdata = rom_rdata;
   assign bus_b.err_clr   = err_clr;

   bus_interconnect_4 #(
      .RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .MMI_AW(MMI_AW),
      .RAM_LAT(3), .ROM_LAT(1), .MMI_TIMEOUT(4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   bus_interconnect_4 #(
      .RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .MMI_AW(MMI_AW),
      .RAM_LAT(3), .ROM_LAT(1), .MMI_TIMEOUT(255)
   ) u_dut_slow (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   // Observed control vector {rom_en, ram_en, mmi_valid, mem_ready} of the selected DUT
   always_comb begin
      if (use_slow) begin
         act_ctl   = {bus_b.rom_en, bus_b.ram_en, bus_b.mmi_valid, bus_b.mem_ready};
         act_rdata = bus_b.mem_rdata;
      end else begin
         act_ctl   = {bus_a.rom_en, bus_a.ram_en, bus_a.mmi_valid, bus_a.mem_ready};
         act_rdata = bus_a.mem_rdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic ctl(input string tag, input logic [3:0] e);
      @(negedge clk);
      check(tag, {28'd0, act_ctl}, {28'd0, e});
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [31:0] a, input logic [3:0] ws,
                            input logic ins, input logic [31:0] exp);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wstrb = ws;
      mem_instr = ins;
      exp_q.push_back(exp);
   endtask

   // Scoreboard: every ready pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (act_ctl[0] === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ready", {31'd0, act_ctl[0]}, 32'd0);
         end else begin
            exp_rd = exp_q.pop_front();
            check("rdata", act_rdata, exp_rd);
         end
      end
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      ctl("reset_ctl", 4'b0000);
      check("reset_bus_err", {31'd0, bus_a.bus_err}, 32'd0);
      check("reset_err_addr", bus_a.err_addr, 32'd0);
      check("reset_rdata", bus_a.mem_rdata, 32'd0);
      adv();
      reset = 1'b1;

      // ROM fetch, accepted in the first cycle after reset release
      rom_rdata = 32'h1111_2222;
      start_req(32'h0000_0100, 4'h0, 1'b1, 32'h1111_2222);
      ctl("rom_t", 4'b1000);
      check("rom_addr", 32'(bus_a.rom_addr), 32'h0000_0040);
      adv();
      ctl("rom_t1", 4'b1001);
      adv();
      mem_valid = 1'b0;
      rom_rdata = 32'h0BAD_0000;
      ctl("rom_done", 4'b0000);
      check("rom_hold", act_rdata, 32'h1111_2222);
      adv();

      // RAM write, 3-cycle latency
      ram_rdata = 32'h3333_4444;
      mem_wdata = 32'hCAFE_F00D;
      start_req(32'h0020_0008, 4'hF, 1'b0, 32'h3333_4444);
      ctl("ram_t", 4'b0100);
      check("ram_addr", 32'(bus_a.ram_addr), 32'd2);
      check("slv_wdata", bus_a.slv_wdata, 32'hCAFE_F00D);
      check("slv_wstrb", {28'd0, bus_a.slv_wstrb}, 32'hF);
      adv();
      ctl("ram_t1", 4'b0100);
      adv();
      ctl("ram_t2", 4'b0100);
      adv();
      ctl("ram_t3", 4'b0101);
      adv();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      ctl("ram_t4_done", 4'b0000);
      adv();

      // MMI zero-wait completion
      mmi_rdata = 32'h7777_8888;
      mmi_ready = 1'b1;
      start_req(32'h0010_0008, 4'h0, 1'b0, 32'h7777_8888);
      ctl("mmi0_t", 4'b0011);
      check("mmi0_addr", 32'(bus_a.mmi_addr), 32'd2);
      adv();
      mem_valid = 1'b0;
      mmi_ready = 1'b0;
      ctl("mmi0_done", 4'b0000);
      adv();

      // MMI read answered at t+5 on the default-timeout DUT
      use_slow  = 1'b1;
      mmi_rdata = 32'h5555_6666;
      start_req(32'h0010_0004, 4'h0, 1'b0, 32'h5555_6666);
      ctl("mmi5_t", 4'b0010);
      check("mmi5_addr", 32'(bus_b.mmi_addr), 32'd1);
      adv();
      for (int i = 1; i < 5; i++) begin
         ctl("mmi5_wait", 4'b0010);
         adv();
      end
      mmi_ready = 1'b1;
      ctl("mmi5_ready", 4'b0011);
      adv();
      mem_valid = 1'b0;
      mmi_ready = 1'b0;
      mmi_rdata = 32'h0;
      ctl("mmi5_done", 4'b0000);
      check("mmi5_hold", act_rdata, 32'h5555_6666);
      adv();
      use_slow = 1'b0;

      // MMI timeout with MMI_TIMEOUT=4
      start_req(32'h0010_0004, 4'h0, 1'b0, BAD);
      for (int i = 0; i < 4; i++) begin
         ctl("mmito_wait", 4'b0010);
         adv();
      end
      ctl("mmito_drop", 4'b0000);
      check("mmito_no_err_yet", {31'd0, bus_a.bus_err}, 32'd0);
      adv();
      ctl("mmito_err", 4'b0001);
      adv();
      mem_valid = 1'b0;
      ctl("mmito_done", 4'b0000);
      check("mmito_bus_err", {31'd0, bus_a.bus_err}, 32'd1);
      check("mmito_err_addr", bus_a.err_addr, 32'h0010_0004);
      check("mmito_hold", act_rdata, BAD);
      adv();
      err_clr = 1'b1;
      ctl("clr1", 4'b0000);
      adv();
      err_clr = 1'b0;
      ctl("clr1_done", 4'b0000);
      check("clr1_bus_err", {31'd0, bus_a.bus_err}, 32'd0);
      adv();

      // Unmapped access, then ROM write: first error address is kept
      start_req(32'h0030_0000, 4'h0, 1'b0, BAD);
      ctl("unmapped_t", 4'b0000);
      adv();
      ctl("unmapped_err", 4'b0001);
      adv();
      mem_valid = 1'b0;
      ctl("unmapped_done", 4'b0000);
      check("unmapped_bus_err", {31'd0, bus_a.bus_err}, 32'd1);
      check("unmapped_err_addr", bus_a.err_addr, 32'h0030_0000);
      adv();
      start_req(32'h0000_0010, 4'h3, 1'b0, BAD);
      ctl("romwr_t", 4'b0000);
      adv();
      ctl("romwr_err", 4'b0001);
      adv();
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      ctl("romwr_done", 4'b0000);
      check("romwr_err_addr", bus_a.err_addr, 32'h0030_0000);
      adv();

      // MMI fetch error together with err_clr: set wins
      start_req(32'h0010_0000, 4'h0, 1'b1, BAD);
      err_clr = 1'b1;
      ctl("mmifetch_t", 4'b0000);
      adv();
      err_clr = 1'b0;
      ctl("mmifetch_err", 4'b0001);
      check("set_wins_bus_err", {31'd0, bus_a.bus_err}, 32'd1);
      check("set_wins_err_addr", bus_a.err_addr, 32'h0030_0000);
      adv();
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      ctl("mmifetch_done", 4'b0000);
      adv();

      // Clear alone, then a new error reloads err_addr
      err_clr = 1'b1;
      ctl("clr2", 4'b0000);
      adv();
      err_clr = 1'b0;
      ctl("clr2_done", 4'b0000);
      check("clr2_bus_err", {31'd0, bus_a.bus_err}, 32'd0);
      adv();
      start_req(32'h0030_0040, 4'h0, 1'b0, BAD);
      ctl("reload_t", 4'b0000);
      adv();
      ctl("reload_err", 4'b0001);
      adv();
      mem_valid = 1'b0;
      ctl("reload_done", 4'b0000);
      check("reload_err_addr", bus_a.err_addr, 32'h0030_0040);
      adv();

      // Reset during a RAM access aborts it without mem_ready
      mem_valid = 1'b1;
      mem_addr  = 32'h0020_000C;
      mem_wstrb = 4'h0;
      mem_instr = 1'b0;
      ctl("rstram_t", 4'b0100);
      adv();
      reset = 1'b0;
      ctl("rstram_t1", 4'b0100);
      adv();
      reset = 1'b1;
      rom_rdata = 32'h9999_AAAA;
      start_req(32'h0000_0200, 4'h0, 1'b1, 32'h9999_AAAA);
      ctl("post_rst_t", 4'b1000);
      check("post_rst_bus_err", {31'd0, bus_a.bus_err}, 32'd0);
      check("post_rst_err_addr", bus_a.err_addr, 32'd0);
      check("post_rst_hold", act_rdata, 32'd0);
      adv();
      ctl("post_rst_t1", 4'b1001);
      adv();
      mem_valid = 1'b0;
      ctl("post_rst_done", 4'b0000);
      adv();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
